// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised single-clock FIFO with occupancy counter,
// almost-full/almost-empty thresholds, sticky error flags, synchronous flush
// and an optional first-word-fall-through read port.
module sync_fifo_param #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = 0
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       w_enable,
  input  logic [DATA_W-1:0]          write_data,
  input  logic                       r_enable,
  output logic [DATA_W-1:0]          read_data,
  output logic                       read_valid,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;
  logic          rd_acc, wr_acc;

  assign empty        = (count_q == '0);
  assign full         = (count_q == DEPTH_C);
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  // A full FIFO still takes a write when a pop frees a slot in the same cycle.
  assign rd_acc = r_enable && !empty;
  assign wr_acc = w_enable && (!full || rd_acc);

  // Next-state for pointers, the single occupancy counter and sticky flags.
  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (flush) begin
      wptr_d      = '0;
      rptr_d      = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (wr_acc) wptr_d = wptr_q + PW'(1);
      if (rd_acc) rptr_d = rptr_q + PW'(1);
      case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      if (w_enable && full && !rd_acc) overflow_d = 1'b1;
      if (r_enable && empty) underflow_d = 1'b1;
    end
  end

  // Control state registers, cleared asynchronously by reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage array; contents survive reset and are simply overwritten later.
  always_ff @(posedge clock) begin
    if (wr_acc && !flush) mem[wptr_q] <= write_data;
  end

  if (FWFT != 0) begin : g_fwft
    assign read_data  = mem[rptr_q];
    assign read_valid = !empty;
  end else begin : g_registered
    logic [DATA_W-1:0] read_data_q, read_data_d;
    logic              read_valid_q, read_valid_d;

    // Registered read port: a pop loads the head word, otherwise data holds.
    always_comb begin
      read_data_d  = read_data_q;
      read_valid_d = 1'b0;
      if (flush) begin
        read_data_d = '0;
      end else if (rd_acc) begin
        read_data_d  = mem[rptr_q];
        read_valid_d = 1'b1;
      end
    end

    // Read port registers, cleared asynchronously by reset.
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        read_data_q  <= '0;
        read_valid_q <= 1'b0;
      end else begin
        read_data_q  <= read_data_d;
        read_valid_q <= read_valid_d;
      end
    end

    assign read_data  = read_data_q;
    assign read_valid = read_valid_q;
  end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed self-checking bench for sync_fifo_param; drives one stimulus
// stream into a registered-read instance and a FWFT instance side by side.
module tb_sync_fifo_param;

  logic       clock;
  logic       reset;
  logic       flush;
  logic       w_enable;
  logic [7:0] write_data;
  logic       r_enable;

  logic [7:0] read_data0, read_data1;
  logic       read_valid0, read_valid1;
  logic       full0, full1, empty0, empty1;
  logic       af0, af1, ae0, ae1;
  logic [4:0] count0, count1;
  logic       ovf0, ovf1, unf0, unf1;

  int errors = 0;
  int checks = 0;

  sync_fifo_param #(.DATA_W(8), .DEPTH(16), .FWFT(0)) u_reg (
    .clock(clock), .reset(reset), .flush(flush),
    .w_enable(w_enable), .write_data(write_data), .r_enable(r_enable),
    .read_data(read_data0), .read_valid(read_valid0),
    .full(full0), .empty(empty0), .almost_full(af0), .almost_empty(ae0),
    .count(count0), .overflow(ovf0), .underflow(unf0)
  );

  sync_fifo_param #(.DATA_W(8), .DEPTH(16), .FWFT(1)) u_fwft (
    .clock(clock), .reset(reset), .flush(flush),
    .w_enable(w_enable), .write_data(write_data), .r_enable(r_enable),
    .read_data(read_data1), .read_valid(read_valid1),
    .full(full1), .empty(empty1), .almost_full(af1), .almost_empty(ae1),
    .count(count1), .overflow(ovf1), .underflow(unf1)
  );

  // Free-running 10ns clock.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Drive one cycle of inputs, then sample 1ns after the capturing edge.
  task automatic applyStimulus(input logic w, input logic [7:0] d,
                               input logic r, input logic f);
    w_enable   = w;
    write_data = d;
    r_enable   = r;
    flush      = f;
    @(posedge clock);
    #1;
  endtask

  // Count one comparison and report it if observed differs from expected.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Directed test sequence.
  initial begin
    reset = 1'b1; flush = 1'b0; w_enable = 1'b0; write_data = 8'h00; r_enable = 1'b0;
    #12;
    checkOutput("rst_count", count0, 0);
    checkOutput("rst_empty", empty0, 1);
    checkOutput("rst_full", full0, 0);
    checkOutput("rst_ae", ae0, 1);
    checkOutput("rst_af", af0, 0);
    checkOutput("rst_ovf", ovf0, 0);
    checkOutput("rst_unf", unf0, 0);
    checkOutput("rst_rdata", read_data0, 0);
    checkOutput("rst_rvalid", read_valid0, 0);
    checkOutput("rst_fwft_rvalid", read_valid1, 0);
    #1 reset = 1'b0;

    // Fill 0x00..0x0F, then one dropped write.
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 8'(i), 1'b0, 1'b0);
      checkOutput("fill_count", count0, i + 1);
      checkOutput("fill_af", af0, ((i + 1) >= 14) ? 1 : 0);
    end
    checkOutput("fill_full", full0, 1);
    checkOutput("fill_fwft_head", read_data1, 8'h00);
    checkOutput("fill_fwft_valid", read_valid1, 1);
    applyStimulus(1'b1, 8'hAA, 1'b0, 1'b0);
    checkOutput("ovf_flag", ovf0, 1);
    checkOutput("ovf_count", count0, 16);
    checkOutput("ovf_full", full0, 1);

    // Drain in order; registered data lands one edge after r_enable.
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      checkOutput("drain_data", read_data0, i);
      checkOutput("drain_valid", read_valid0, 1);
      checkOutput("drain_count", count0, 15 - i);
      checkOutput("drain_ae", ae0, ((15 - i) <= 2) ? 1 : 0);
    end
    checkOutput("drain_empty", empty0, 1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("idle_valid", read_valid0, 0);
    checkOutput("idle_hold", read_data0, 8'h0F);

    // Underflow is sticky until flush.
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("unf_flag", unf0, 1);
    checkOutput("unf_valid", read_valid0, 0);
    checkOutput("unf_count", count0, 0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("unf_sticky", unf0, 1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("flush_unf", unf0, 0);
    checkOutput("flush_ovf", ovf0, 0);
    checkOutput("flush_rdata", read_data0, 0);
    checkOutput("flush_empty", empty0, 1);

    // Full FIFO with simultaneous read and write.
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 8'h55, 1'b1, 1'b0);
      checkOutput("rw_count", count0, 16);
      checkOutput("rw_full", full0, 1);
      checkOutput("rw_ovf", ovf0, 0);
      checkOutput("rw_data", read_data0, 8'h10 + k);
    end
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      checkOutput("rw_drain", read_data0, (i < 12) ? (8'h14 + i) : 8'h55);
    end
    checkOutput("rw_empty", empty0, 1);

    // Pointer wrap with alternating single write and read.
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
      checkOutput("wrap_count1", count0, 1);
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      checkOutput("wrap_data", read_data0, 8'h80 + i);
      checkOutput("wrap_count0", count0, 0);
    end
    checkOutput("wrap_ovf", ovf0, 0);
    checkOutput("wrap_unf", unf0, 0);

    // FWFT: written word visible next cycle without a pop.
    applyStimulus(1'b1, 8'h3C, 1'b0, 1'b0);
    checkOutput("fwft_data", read_data1, 8'h3C);
    checkOutput("fwft_valid", read_valid1, 1);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("fwft_pop_empty", empty1, 1);
    checkOutput("fwft_pop_valid", read_valid1, 0);

    // Asynchronous reset mid-cycle discards buffered data.
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'(8'hA0 + i), 1'b0, 1'b0);
    checkOutput("pre_rst_count", count0, 5);
    w_enable = 1'b0;
    #2 reset = 1'b1;
    #1;
    checkOutput("arst_count", count0, 0);
    checkOutput("arst_empty", empty0, 1);
    checkOutput("arst_rdata", read_data0, 0);
    checkOutput("arst_fwft_valid", read_valid1, 0);
    #2 reset = 1'b0;
    applyStimulus(1'b1, 8'h66, 1'b0, 1'b0);
    checkOutput("post_count", count0, 1);
    checkOutput("post_fwft_data", read_data1, 8'h66);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("post_data", read_data0, 8'h66);
    checkOutput("post_empty", empty0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
